// File: rtl/arith_fp_pkg.sv
// IEEE-754 format constants, classification types and the shared field decoder
// used by the arith float<->int operators.
package arith_fp_pkg;

    localparam int F32_EXP_W = 8;
    localparam int F32_MAN_W = 23;
    localparam int F32_BIAS  = 127;
    localparam int F64_EXP_W = 11;
    localparam int F64_MAN_W = 52;
    localparam int F64_BIAS  = 1023;

    // Unbiased exponent spans -1023..1024 for binary64, so 13 signed bits suffice.
    localparam int E_W = 13;
    localparam int M_W = F64_MAN_W + 1;

    typedef enum logic [2:0] {
        ZERO,
        SUBNORM,
        NORMAL,
        INF,
        NAN
    } fp_class_e;

    typedef struct packed {
        logic                  sign;
        fp_class_e             cls;
        logic signed [E_W-1:0] e;
        logic [M_W-1:0]        m;
    } fp_decoded_t;

    function automatic int exp_w(input int in_width);
        return (in_width == 64) ? F64_EXP_W : F32_EXP_W;
    endfunction

    function automatic int man_w(input int in_width);
        return (in_width == 64) ? F64_MAN_W : F32_MAN_W;
    endfunction

    function automatic int bias(input int in_width);
        return (in_width == 64) ? F64_BIAS : F32_BIAS;
    endfunction

    // Binary32 operands arrive zero-extended in raw[31:0]; M is right-aligned.
    function automatic fp_decoded_t fp_decode(input logic [63:0] raw, input logic is_f64);
        fp_decoded_t d;
        logic [10:0] ex;
        logic [51:0] man;
        logic        ex_ones;
        d = '0;
        if (is_f64) begin
            d.sign  = raw[63];
            ex      = raw[62:52];
            man     = raw[51:0];
            ex_ones = &raw[62:52];
            d.e     = E_W'({2'b00, ex}) - E_W'(F64_BIAS);
            d.m     = {1'b1, man};
        end else begin
            d.sign  = raw[31];
            ex      = {3'b000, raw[30:23]};
            man     = {29'd0, raw[22:0]};
            ex_ones = &raw[30:23];
            d.e     = E_W'({2'b00, ex}) - E_W'(F32_BIAS);
            d.m     = {29'd0, 1'b1, raw[22:0]};
        end
        if (ex == '0)
            d.cls = (man == '0) ? ZERO : SUBNORM;
        else if (ex_ones)
            d.cls = (man == '0) ? INF : NAN;
        else
            d.cls = NORMAL;
        return d;
    endfunction

endpackage

// File: rtl/arith_fp_decode.sv
// Combinational IEEE-754 classifier: splits an operand into sign, class,
// unbiased exponent and significand with the hidden bit restored.
module arith_fp_decode
    import arith_fp_pkg::*;
#(
    parameter int IN_WIDTH = 32
) (
    input  logic [IN_WIDTH-1:0] a_data,
    output fp_decoded_t         dec
);

    assign dec = fp_decode(64'(a_data), IN_WIDTH == 64);

endmodule

// File: rtl/arith_fptoui_pipe.sv
// Two-stage float -> unsigned integer converter, round toward zero with
// saturation, behind a valid/ready handshake.
module arith_fptoui_pipe
    import arith_fp_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [IN_WIDTH-1:0]  a_data,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [OUT_WIDTH-1:0] result_data,
    output logic                 result_invalid
);

    localparam int MAN_W = man_w(IN_WIDTH);
    localparam int SH_W  = (OUT_WIDTH > MAN_W + 1) ? OUT_WIDTH : MAN_W + 1;

    if (IN_WIDTH != 32 && IN_WIDTH != 64) begin : g_bad_in_width
        $fatal(1, "arith_fptoui_pipe: IN_WIDTH must be 32 or 64");
    end
    if (OUT_WIDTH < 1 || OUT_WIDTH > 64) begin : g_bad_out_width
        $fatal(1, "arith_fptoui_pipe: OUT_WIDTH must be in 1..64");
    end

    fp_decoded_t dec;
    fp_decoded_t s1_dec;
    logic        s1_valid;
    logic        s2_valid;
    logic        s1_adv;

    arith_fp_decode #(.IN_WIDTH(IN_WIDTH)) u_decode (
        .a_data (a_data),
        .dec    (dec)
    );

    assign s1_adv       = !s2_valid || result_ready;
    assign a_ready      = !s1_valid || s1_adv;
    assign result_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_dec   <= '0;
        end else if (a_ready) begin
            s1_valid <= a_valid;
            if (a_valid)
                s1_dec <= dec;
        end
    end

    logic signed [E_W-1:0] e;
    logic [E_W-1:0]        sh_up;
    logic [E_W-1:0]        sh_dn;
    logic [SH_W-1:0]       m_ext;
    logic [OUT_WIDTH-1:0]  s2_data;
    logic                  s2_inv;

    assign e     = $signed(s1_dec.e);
    assign m_ext = SH_W'(s1_dec.m[MAN_W:0]);

    // E < OUT_WIDTH is established before either shift, so neither can overflow.
    always_comb begin
        s2_data = '0;
        s2_inv  = 1'b0;
        sh_up   = e[E_W-1:0] - E_W'(MAN_W);
        sh_dn   = E_W'(MAN_W) - e[E_W-1:0];
        case (s1_dec.cls)
            NAN: s2_inv = 1'b1;
            INF: begin
                s2_inv = 1'b1;
                if (!s1_dec.sign)
                    s2_data = '1;
            end
            NORMAL: begin
                if (e < 0) begin
                    s2_data = '0;
                end else if (s1_dec.sign) begin
                    s2_inv = 1'b1;
                end else if (e >= E_W'(OUT_WIDTH)) begin
                    s2_inv  = 1'b1;
                    s2_data = '1;
                end else if (e >= E_W'(MAN_W)) begin
                    s2_data = OUT_WIDTH'(m_ext << sh_up);
                end else begin
                    s2_data = OUT_WIDTH'(m_ext >> sh_dn);
                end
            end
            default: s2_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid       <= 1'b0;
            result_data    <= '0;
            result_invalid <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result_data    <= s2_data;
                result_invalid <= s2_inv;
            end
        end
    end

endmodule
